seg_scan_display: RTL and testbench

- Downstream stage of the 4-bit calculator core. Consumes its 8-bit unsigned magnitude `op` and `neg` sign flag.
- Converts the magnitude to three BCD digits using a sequential (one shift per cycle) double-dabble.
- Drives a 4-digit multiplexed common-anode seven-segment display: units, tens, hundreds, sign.
- Supports optional leading-zero blanking.

---
 rtl/seg_pkg.sv | 54 +++++
 rtl/bin2bcd_seq.sv | 105 ++++++++++
 rtl/seg_scan_display.sv | 91 +++++++++
 tb/tb_seg_scan_display.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, types and helpers for the seven-segment scan display.
package seg_pkg;

  // Segment codes {a,b,c,d,e,f,g,dp}, active-high.
  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_MINUS = 8'h02;

  // Common-anode digit enables, active-low one-hot.
  localparam logic [3:0] EN_UNITS = 4'b0111;
  localparam logic [3:0] EN_TENS  = 4'b1011;
  localparam logic [3:0] EN_HUND  = 4'b1101;
  localparam logic [3:0] EN_SIGN  = 4'b1110;
  localparam logic [3:0] EN_NONE  = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } conv_state_t;

  // BCD digit to segment pattern; non-decimal codes render blank.
  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction applied to a nibble before each shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle, 8 cycles per conversion.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for load; committed digits held
// ST_SHIFT | adjusting and shifting; commits after the 8th shift
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] op,
  input  logic       neg,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic       sign
);

  conv_state_t state_q;
  logic [7:0]  shreg_q, shreg_d;
  logic [3:0]  units_q, units_d;
  logic [3:0]  tens_q, tens_d;
  // Hundreds can be at most 1 before the final shift, so one bit suffices.
  logic        hund_q, hund_d;
  logic [2:0]  cnt_q;
  logic        neg_q;
  logic        busy_q, done_q, sign_q;
  logic [3:0]  bcd1_q, bcd2_q, bcd3_q;
  logic [3:0]  adj_u, adj_t;

  // One double-dabble step: correct the nibbles, then shift everything left by one.
  always_comb begin
    adj_u   = dd_adjust(units_q);
    adj_t   = dd_adjust(tens_q);
    units_d = {adj_u[2:0], shreg_q[7]};
    tens_d  = {adj_t[2:0], adj_u[3]};
    hund_d  = adj_t[3];
    shreg_d = {shreg_q[6:0], 1'b0};
  end

  // Conversion FSM with registered busy/done/digit outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      units_q <= '0;
      tens_q  <= '0;
      hund_q  <= 1'b0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      bcd1_q  <= '0;
      bcd2_q  <= '0;
      bcd3_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            shreg_q <= op;
            neg_q   <= neg;
            units_q <= '0;
            tens_q  <= '0;
            hund_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg_q <= shreg_d;
          units_q <= units_d;
          tens_q  <= tens_d;
          hund_q  <= hund_d;
          cnt_q   <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            bcd1_q  <= units_d;
            bcd2_q  <= tens_d;
            bcd3_q  <= {2'b00, hund_q, hund_d};
            // Sign is committed with the digits so the display never mixes old and new.
            sign_q  <= neg_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd1 = bcd1_q;
  assign bcd2 = bcd2_q;
  assign bcd3 = bcd3_q;
  assign sign = sign_q;

endmodule

// File: rtl/seg_scan_display.sv
// Signed 3-digit result display: BCD conversion plus a free-running 4-digit scanner.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 2000,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] op,
  input  logic       neg,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic [3:0] control,
  output logic [7:0] display
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pre_q;
  digit_idx_t    idx_q;
  logic [3:0]    control_q, control_d;
  logic [7:0]    display_q, display_d;
  logic          sign_c;
  logic          is_zero, show_sign, blank_tens, blank_hund;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .op    (op),
    .neg   (neg),
    .busy  (busy),
    .done  (done),
    .bcd1  (bcd1),
    .bcd2  (bcd2),
    .bcd3  (bcd3),
    .sign  (sign_c)
  );

  // Select enable and segments for the digit the scan index points at.
  always_comb begin
    is_zero    = (bcd1 == 4'd0) && (bcd2 == 4'd0) && (bcd3 == 4'd0);
    show_sign  = sign_c && !is_zero;
    blank_hund = (BLANK_LZ != 0) && (bcd3 == 4'd0);
    blank_tens = blank_hund && (bcd2 == 4'd0);
    control_d  = EN_UNITS;
    display_d  = seg_encode(bcd1);
    case (idx_q)
      2'd1: begin
        control_d = EN_TENS;
        display_d = blank_tens ? SEG_BLANK : seg_encode(bcd2);
      end
      2'd2: begin
        control_d = EN_HUND;
        display_d = blank_hund ? SEG_BLANK : seg_encode(bcd3);
      end
      2'd3: begin
        control_d = EN_SIGN;
        display_d = show_sign ? SEG_MINUS : SEG_BLANK;
      end
      default: ;
    endcase
  end

  // Prescaler and scan index; outputs refresh together once per dwell period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q     <= '0;
      idx_q     <= '0;
      control_q <= EN_NONE;
      display_q <= SEG_BLANK;
    end else if (pre_q == PRE_TC) begin
      pre_q     <= '0;
      idx_q     <= idx_q + 2'd1;
      control_q <= control_d;
      display_q <= display_d;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  assign control = control_q;
  assign display = display_q;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

  localparam int DIV = 4;
  localparam logic [7:0] SEG_TAB [0:15] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, load, neg;
  logic [7:0] op;
  logic       busy, done;
  logic [3:0] bcd1, bcd2, bcd3, control;
  logic [7:0] display;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seg_scan_display #(.SCAN_DIV(DIV), .BLANK_LZ(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .op      (op),
    .neg     (neg),
    .busy    (busy),
    .done    (done),
    .bcd1    (bcd1),
    .bcd2    (bcd2),
    .bcd3    (bcd3),
    .control (control),
    .display (display)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load a value, check busy length and done latency, then score the committed digits.
  // Returns in the cycle where done is high, so a caller may load again right away.
  task automatic convert(input logic [7:0] v, input logic s);
    exp_t e;
    int   bc;
    int   done_at;
    bit   got;
    e.h = 4'(v / 100);
    e.t = 4'((v / 10) % 10);
    e.u = 4'(v % 10);
    sb.push_back(e);
    load = 1'b1; op = v; neg = s;
    step();
    load = 1'b0;
    bc = busy ? 1 : 0;
    got = 1'b0;
    done_at = 0;
    for (int k = 1; k <= 12 && !got; k++) begin
      step();
      if (done) begin
        got = 1'b1;
        done_at = k;
      end else if (busy) begin
        bc++;
      end
    end
    chk(32'(got), 1, "done_seen");
    chk(done_at, 8, "done_latency");
    chk(bc, 8, "busy_cycles");
    chk(32'(busy), 0, "busy_low_at_done");
    if (got) begin
      e = sb.pop_front();
      chk(32'(bcd3), 32'(e.h), "bcd3");
      chk(32'(bcd2), 32'(e.t), "bcd2");
      chk(32'(bcd1), 32'(e.u), "bcd1");
    end
  endtask

  // Wait for a fresh scan of the given digit, then compare its segments.
  task automatic check_digit(input logic [3:0] ctrl, input logic [7:0] exp, input string tag);
    int n = 0;
    while (control === ctrl && n < 40) begin step(); n++; end
    while (control !== ctrl && n < 40) begin step(); n++; end
    chk(32'(n < 40), 1, {tag, "_timeout"});
    chk(32'(display), 32'(exp), tag);
  endtask

  initial begin
    logic [3:0] ord_ctrl [0:3];
    logic [7:0] ord_disp [0:3];
    int         idx, cnt, ndone;
    exp_t       e;

    reset = 1'b0; load = 1'b0; op = 8'd0; neg = 1'b0;
    #12;
    chk(32'(busy), 0, "rst_busy");
    chk(32'(done), 0, "rst_done");
    chk(32'({bcd3, bcd2, bcd1}), 0, "rst_bcd");
    chk(32'(control), 32'h0F, "rst_control");
    chk(32'(display), 0, "rst_display");

    @(posedge clk); #1;
    reset = 1'b1;
    step(); step(); step();
    chk(32'(control), 32'h0F, "pre_first_scan");
    step();
    chk(32'(control), 32'b0111, "first_scan_ctrl");
    chk(32'(display), 32'hFC, "first_scan_disp");

    // 255: full-range conversion and scan order/dwell check.
    convert(8'd255, 1'b0);
    step();
    chk(32'(done), 0, "done_pulse_width");
    check_digit(4'b0111, 8'hB6, "u255");
    ord_ctrl[0] = 4'b0111; ord_ctrl[1] = 4'b1011; ord_ctrl[2] = 4'b1101; ord_ctrl[3] = 4'b1110;
    ord_disp[0] = 8'hB6;   ord_disp[1] = 8'hB6;   ord_disp[2] = 8'hDA;   ord_disp[3] = 8'h00;
    idx = 0;
    for (int i = 1; i <= 8; i++) begin
      cnt = 0;
      while (control === ord_ctrl[idx] && cnt < 10) begin step(); cnt++; end
      chk(cnt, DIV, "dwell");
      idx = (idx + 1) % 4;
      chk(32'(control), 32'(ord_ctrl[idx]), "scan_ctrl");
      chk(32'(display), 32'(ord_disp[idx]), "scan_disp");
    end

    // 7 negative: leading zeros blank, minus shown.
    convert(8'd7, 1'b1);
    check_digit(4'b0111, 8'hE0, "u7");
    check_digit(4'b1011, 8'h00, "t7");
    check_digit(4'b1101, 8'h00, "h7");
    check_digit(4'b1110, 8'h02, "s7");

    // Negative zero shows as plain 0.
    convert(8'd0, 1'b1);
    check_digit(4'b0111, 8'hFC, "u0");
    check_digit(4'b1011, 8'h00, "t0");
    check_digit(4'b1101, 8'h00, "h0");
    check_digit(4'b1110, 8'h00, "s0");

    // Load in the done cycle is accepted.
    convert(8'd12, 1'b0);
    convert(8'd34, 1'b1);
    check_digit(4'b0111, 8'h66, "u34");
    check_digit(4'b1011, 8'hF2, "t34");
    check_digit(4'b1110, 8'h02, "s34");

    // 100 with a second load at +3 that must be ignored.
    e.h = 4'd1; e.t = 4'd0; e.u = 4'd0;
    sb.push_back(e);
    load = 1'b1; op = 8'd100; neg = 1'b0;
    step();
    load = 1'b0;
    step(); step();
    load = 1'b1; op = 8'd5; neg = 1'b1;
    step();
    load = 1'b0;
    cnt = 0;
    while (!done && cnt < 12) begin step(); cnt++; end
    chk(cnt, 5, "busy_load_done_at");
    if (done) begin
      e = sb.pop_front();
      chk(32'({bcd3, bcd2, bcd1}), 32'({e.h, e.t, e.u}), "bcd_100");
    end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin step(); if (done) ndone++; end
    chk(ndone, 0, "ignored_load_no_done");
    check_digit(4'b1011, 8'hFC, "t100");
    check_digit(4'b1101, 8'h60, "h100");
    check_digit(4'b1110, 8'h00, "s100");

    // Reset mid-conversion of 99.
    load = 1'b1; op = 8'd99; neg = 1'b1;
    step();
    load = 1'b0;
    step(); step(); step(); step();
    #2;
    reset = 1'b0;
    #1;
    chk(32'(busy), 0, "midrst_busy");
    chk(32'({bcd3, bcd2, bcd1}), 0, "midrst_bcd");
    chk(32'(control), 32'h0F, "midrst_control");
    chk(32'(display), 0, "midrst_display");
    ndone = 0;
    for (int i = 0; i < 3; i++) begin step(); if (done) ndone++; end
    chk(ndone, 0, "midrst_no_done");
    reset = 1'b1;
    step();
    convert(8'd42, 1'b0);
    check_digit(4'b0111, 8'hDA, "u42");
    check_digit(4'b1011, 8'h66, "t42");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
